mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
// Imported by the arbiter and by anything that needs its encodings.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WEN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one memory port.
// One transaction in flight; completion is a registered ok pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [WEN_W-1:0]  data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [WEN_W-1:0]  mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  arb_state_t state;
  owner_t     owner;
  owner_t     last_grant;
  logic       grant_data;
  logic       finish;

  always_comb begin
    grant_data = 1'b0;
    unique case (1'b1)
      (data_req && inst_req):
        grant_data = (DATA_FIRST != 0) ? 1'b1
                   : (last_grant == OWN_INST);
      (data_req && !inst_req):
        grant_data = 1'b1;
      default:
        grant_data = 1'b0;
    endcase
  end

  // data_ok alongside addr_ok only counts while still in REQ
  assign finish = ((state == ST_REQ) && mem_addr_ok && mem_data_ok)
               || ((state == ST_WAIT) && mem_data_ok);

  assign stall = (inst_req & ~inst_ok) | (data_req & ~data_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_INST;
      last_grant <= OWN_DATA;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wen    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_ok    <= 1'b0;
      data_ok    <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      inst_ok <= 1'b0;
      data_ok <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (inst_req || data_req) begin
            owner      <= grant_data ? OWN_DATA : OWN_INST;
            last_grant <= grant_data ? OWN_DATA : OWN_INST;
            mem_addr   <= grant_data ? data_addr : inst_addr;
            mem_wr     <= grant_data & data_wr;
            mem_wen    <= (grant_data && data_wr) ? data_wen : '0;
            mem_wdata  <= grant_data ? data_wdata : '0;
            mem_req    <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_addr_ok) begin
            mem_req <= 1'b0;
            state   <= mem_data_ok ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_data_ok) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
      endcase
      if (finish) begin
        if (owner == OWN_INST) begin
          inst_rdata <= mem_rdata;
          inst_ok    <= 1'b1;
        end else begin
          if (!mem_wr) begin
            data_rdata <= mem_rdata;
          end
          data_ok <= 1'b1;
        end
      end
    end
  end

endmodule
